// File: rtl/cfg_ctrl_pkg.sv
// Shared definitions for the memory-bank configuration sequencer:
// FSM state encoding, default geometry and counter-width helper.
package cfg_ctrl_pkg;

    localparam int unsigned STATE_W      = 3;
    localparam int unsigned DEF_NUM_BITS = 56;
    localparam int unsigned DEF_WORD_W   = 8;
    localparam int unsigned DEF_WL_PULSE = 2;

    typedef enum logic [STATE_W-1:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_SETUP = 3'd2,
        S_PULSE = 3'd3,
        S_HOLD  = 3'd4,
        S_DONE  = 3'd5
    } cfg_state_e;

    // Bits needed to count 0..n-1, never less than one bit.
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/cfg_wl_pulse_timer.sv
// Down-counter timing the word-line pulse; loaded in SETUP, counted in PULSE.
module cfg_wl_pulse_timer
    import cfg_ctrl_pkg::*;
#(
    parameter int unsigned WL_PULSE = DEF_WL_PULSE
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_load,
    input  logic i_en,
    output logic o_expired_c
);

    localparam int unsigned CNT_W = cnt_w(WL_PULSE + 1);

    logic [CNT_W-1:0] r_cnt;

    // Loaded with WL_PULSE-1 so the last PULSE cycle sees zero.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= CNT_W'(WL_PULSE - 1);
        end else if (i_en && (r_cnt != '0)) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    assign o_expired_c = (r_cnt == '0);

endmodule

// File: rtl/cby_mem_bank_cfg_ctrl.sv
// Configuration sequencer for one memory-bank connection block: takes bitstream
// words over valid/ready and programs each SRAM bit via its bl/wl pair.
module cby_mem_bank_cfg_ctrl
    import cfg_ctrl_pkg::*;
#(
    parameter int unsigned NUM_BITS = DEF_NUM_BITS,
    parameter int unsigned WORD_W   = DEF_WORD_W,
    parameter int unsigned WL_PULSE = DEF_WL_PULSE
) (
    input  logic                            prog_clk,
    input  logic                            pReset,
    input  logic                            start,
    input  logic                            cfg_valid,
    input  logic [WORD_W-1:0]               cfg_data,
    output logic                            cfg_ready,
    output logic [0:NUM_BITS-1]             bl,
    output logic [0:NUM_BITS-1]             wl,
    output logic                            busy,
    output logic                            done,
    output logic                            err_overflow,
    output logic [$clog2(NUM_BITS+1)-1:0]   bit_idx
);

    localparam int unsigned IDX_W = cnt_w(NUM_BITS + 1);
    localparam int unsigned WB_W  = cnt_w(WORD_W);

    cfg_state_e          r_state;
    cfg_state_e          w_state_nxt;
    logic [WORD_W-1:0]   r_shreg;
    logic [WORD_W-1:0]   w_shreg_nxt;
    logic [WB_W-1:0]     r_wbit;
    logic [WB_W-1:0]     w_wbit_nxt;
    logic [IDX_W-1:0]    r_bit_idx;
    logic [IDX_W-1:0]    w_bit_idx_nxt;
    logic [0:NUM_BITS-1] r_bl;
    logic [0:NUM_BITS-1] w_bl_nxt;
    logic [0:NUM_BITS-1] r_wl;
    logic [0:NUM_BITS-1] w_wl_nxt;
    logic                r_cfg_ready;
    logic                w_cfg_ready_nxt;
    logic                r_busy;
    logic                w_busy_nxt;
    logic                r_done;
    logic                w_done_nxt;
    logic                r_err_overflow;
    logic                w_err_nxt;
    logic                w_timer_load;
    logic                w_timer_en;
    logic                w_expired_c;

    assign w_timer_load = (r_state == S_SETUP);
    assign w_timer_en   = (r_state == S_PULSE);

    cfg_wl_pulse_timer #(
        .WL_PULSE (WL_PULSE)
    ) u_pulse_timer (
        .i_clk       (prog_clk),
        .i_rst       (pReset),
        .i_load      (w_timer_load),
        .i_en        (w_timer_en),
        .o_expired_c (w_expired_c)
    );

    // Next-state and next-output computation; every output is registered.
    always_comb begin
        w_state_nxt   = r_state;
        w_shreg_nxt   = r_shreg;
        w_wbit_nxt    = r_wbit;
        w_bit_idx_nxt = r_bit_idx;
        w_err_nxt     = r_err_overflow;
        w_bl_nxt      = r_bl;
        w_wl_nxt      = '0;

        case (r_state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    w_state_nxt   = S_FETCH;
                    w_wbit_nxt    = '0;
                    w_bit_idx_nxt = '0;
                    w_err_nxt     = 1'b0;
                end else if (cfg_valid) begin
                    w_err_nxt = 1'b1;
                end
            end
            S_FETCH: begin
                if (cfg_valid && r_cfg_ready) begin
                    w_shreg_nxt = cfg_data;
                    w_state_nxt = S_SETUP;
                end
            end
            S_SETUP: begin
                w_state_nxt = S_PULSE;
            end
            S_PULSE: begin
                if (w_expired_c) begin
                    w_state_nxt = S_HOLD;
                end
            end
            S_HOLD: begin
                w_bit_idx_nxt = r_bit_idx + IDX_W'(1);
                w_shreg_nxt   = r_shreg >> 1;
                w_wbit_nxt    = r_wbit + WB_W'(1);
                if (r_bit_idx == IDX_W'(NUM_BITS - 1)) begin
                    w_state_nxt = S_DONE;
                end else if (r_wbit == WB_W'(WORD_W - 1)) begin
                    w_state_nxt = S_FETCH;
                    w_wbit_nxt  = '0;
                end else begin
                    w_state_nxt = S_SETUP;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        // bl only moves on entry to SETUP (new bit) or when leaving the bit loop.
        if (w_state_nxt == S_SETUP) begin
            for (int unsigned i = 0; i < NUM_BITS; i++) begin
                w_bl_nxt[i] = (IDX_W'(i) == w_bit_idx_nxt) & w_shreg_nxt[0];
            end
        end else if ((w_state_nxt == S_IDLE) || (w_state_nxt == S_FETCH) ||
                     (w_state_nxt == S_DONE)) begin
            w_bl_nxt = '0;
        end

        if (w_state_nxt == S_PULSE) begin
            for (int unsigned i = 0; i < NUM_BITS; i++) begin
                w_wl_nxt[i] = (IDX_W'(i) == r_bit_idx);
            end
        end

        w_cfg_ready_nxt = (w_state_nxt == S_FETCH);
        w_busy_nxt      = (w_state_nxt == S_FETCH) || (w_state_nxt == S_SETUP) ||
                          (w_state_nxt == S_PULSE) || (w_state_nxt == S_HOLD);
        w_done_nxt      = (w_state_nxt == S_DONE);
    end

    // State and output registers.
    always_ff @(posedge prog_clk) begin
        if (pReset) begin
            r_state        <= S_IDLE;
            r_shreg        <= '0;
            r_wbit         <= '0;
            r_bit_idx      <= '0;
            r_bl           <= '0;
            r_wl           <= '0;
            r_cfg_ready    <= 1'b0;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
            r_err_overflow <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_shreg        <= w_shreg_nxt;
            r_wbit         <= w_wbit_nxt;
            r_bit_idx      <= w_bit_idx_nxt;
            r_bl           <= w_bl_nxt;
            r_wl           <= w_wl_nxt;
            r_cfg_ready    <= w_cfg_ready_nxt;
            r_busy         <= w_busy_nxt;
            r_done         <= w_done_nxt;
            r_err_overflow <= w_err_nxt;
        end
    end

    assign cfg_ready    = r_cfg_ready;
    assign bl           = r_bl;
    assign wl           = r_wl;
    assign busy         = r_busy;
    assign done         = r_done;
    assign err_overflow = r_err_overflow;
    assign bit_idx      = r_bit_idx;

endmodule

// File: tb/tb_cby_mem_bank_cfg_ctrl.sv
// Scoreboard bench for cby_mem_bank_cfg_ctrl: a 56/8/2 instance and a 10/8/1 instance.
module tb_cby_mem_bank_cfg_ctrl;

    localparam int unsigned A_BITS = 56;
    localparam int unsigned A_W    = 8;
    localparam int unsigned A_P    = 2;
    localparam int unsigned B_BITS = 10;
    localparam int unsigned B_W    = 8;
    localparam int unsigned B_P    = 1;

    typedef struct {
        int   idx;
        logic val;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    logic              a_start, a_cfg_valid, a_cfg_ready, a_busy, a_done, a_err;
    logic [A_W-1:0]    a_cfg_data;
    logic [0:A_BITS-1] a_bl, a_wl;
    logic [5:0]        a_bit_idx;
    logic              b_start, b_cfg_valid, b_cfg_ready, b_busy, b_done, b_err;
    logic [B_W-1:0]    b_cfg_data;
    logic [0:B_BITS-1] b_bl, b_wl;
    logic [3:0]        b_bit_idx;

    exp_t a_q[$];
    exp_t b_q[$];
    int   a_nbits, b_nbits;

    cby_mem_bank_cfg_ctrl #(.NUM_BITS(A_BITS), .WORD_W(A_W), .WL_PULSE(A_P)) u_dut_a (
        .prog_clk(clk), .pReset(rst), .start(a_start), .cfg_valid(a_cfg_valid),
        .cfg_data(a_cfg_data), .cfg_ready(a_cfg_ready), .bl(a_bl), .wl(a_wl),
        .busy(a_busy), .done(a_done), .err_overflow(a_err), .bit_idx(a_bit_idx)
    );

    cby_mem_bank_cfg_ctrl #(.NUM_BITS(B_BITS), .WORD_W(B_W), .WL_PULSE(B_P)) u_dut_b (
        .prog_clk(clk), .pReset(rst), .start(b_start), .cfg_valid(b_cfg_valid),
        .cfg_data(b_cfg_data), .cfg_ready(b_cfg_ready), .bl(b_bl), .wl(b_wl),
        .busy(b_busy), .done(b_done), .err_overflow(b_err), .bit_idx(b_bit_idx)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Instance A monitor: one-hot wl, scoreboard pop on each wl rise, stable bl, pulse width.
    int                a_len = 0;
    logic [0:A_BITS-1] a_prev_wl = '0, a_prev_bl = '0, a_exp;
    exp_t              a_e;
    always @(negedge clk) begin
        if (rst) begin
            a_len     = 0;
            a_prev_wl = '0;
        end else begin
            check("a_wl_onehot", 64'($countones(a_wl) <= 1), 64'(1));
            if (a_wl != '0) begin
                if (a_prev_wl == '0) begin
                    check("a_sb_pending", 64'(a_q.size() > 0), 64'(1));
                    if (a_q.size() > 0) begin
                        a_e = a_q.pop_front();
                        a_exp = '0;
                        a_exp[a_e.idx] = 1'b1;
                        check("a_wl_pos", 64'(a_wl), 64'(a_exp));
                        check("a_bit_idx", 64'(a_bit_idx), 64'(a_e.idx));
                        a_exp[a_e.idx] = a_e.val;
                        check("a_bl_val", 64'(a_bl), 64'(a_exp));
                    end
                end else begin
                    check("a_bl_stable", 64'(a_bl), 64'(a_prev_bl));
                end
                a_len++;
            end else if (a_prev_wl != '0) begin
                check("a_wl_len", 64'(a_len), 64'(A_P));
                a_len = 0;
            end
            a_prev_wl = a_wl;
            a_prev_bl = a_bl;
        end
    end

    // Instance B monitor, same rules with its own geometry.
    int                b_len = 0;
    logic [0:B_BITS-1] b_prev_wl = '0, b_prev_bl = '0, b_exp;
    exp_t              b_e;
    always @(negedge clk) begin
        if (rst) begin
            b_len     = 0;
            b_prev_wl = '0;
        end else begin
            check("b_wl_onehot", 64'($countones(b_wl) <= 1), 64'(1));
            if (b_wl != '0) begin
                if (b_prev_wl == '0) begin
                    check("b_sb_pending", 64'(b_q.size() > 0), 64'(1));
                    if (b_q.size() > 0) begin
                        b_e = b_q.pop_front();
                        b_exp = '0;
                        b_exp[b_e.idx] = 1'b1;
                        check("b_wl_pos", 64'(b_wl), 64'(b_exp));
                        b_exp[b_e.idx] = b_e.val;
                        check("b_bl_val", 64'(b_bl), 64'(b_exp));
                    end
                end else begin
                    check("b_bl_stable", 64'(b_bl), 64'(b_prev_bl));
                end
                b_len++;
            end else if (b_prev_wl != '0) begin
                check("b_wl_len", 64'(b_len), 64'(B_P));
                b_len = 0;
            end
            b_prev_wl = b_wl;
            b_prev_bl = b_bl;
        end
    end

    // Waits for FETCH, optionally idles gap cycles, then hands over one word.
    task automatic a_send(input logic [A_W-1:0] d, input int gap);
        int n = 0;
        while (!a_cfg_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("a_fetch_wait", 64'(a_cfg_ready), 64'(1));
        for (int g = 0; g < gap; g++) begin
            @(negedge clk);
            check("a_gap_ready", 64'(a_cfg_ready), 64'(1));
            check("a_gap_wl", 64'(a_wl), 64'(0));
        end
        a_cfg_valid = 1'b1;
        a_cfg_data  = d;
        for (int b = 0; b < int'(A_W); b++) begin
            if (a_nbits < int'(A_BITS)) begin
                a_q.push_back('{a_nbits, d[b]});
                a_nbits++;
            end
        end
        @(negedge clk);
        a_cfg_valid = 1'b0;
    endtask

    task automatic b_send(input logic [B_W-1:0] d);
        int n = 0;
        while (!b_cfg_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("b_fetch_wait", 64'(b_cfg_ready), 64'(1));
        b_cfg_valid = 1'b1;
        b_cfg_data  = d;
        for (int b = 0; b < int'(B_W); b++) begin
            if (b_nbits < int'(B_BITS)) begin
                b_q.push_back('{b_nbits, d[b]});
                b_nbits++;
            end
        end
        @(negedge clk);
        b_cfg_valid = 1'b0;
    endtask

    // Full pass on instance A; latency measured from the start edge to done.
    task automatic a_run(input int gap_word, input int gap_len, input bit mid_start,
                         input bit rnd, input int exp_lat);
        int t0;
        int n;
        a_nbits = 0;
        a_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
        t0 = cyc;
        check("a_start_busy", 64'(a_busy), 64'(1));
        check("a_start_ready", 64'(a_cfg_ready), 64'(1));
        check("a_start_err", 64'(a_err), 64'(0));
        check("a_start_done", 64'(a_done), 64'(0));
        check("a_start_idx", 64'(a_bit_idx), 64'(0));
        fork
            begin
                for (int w = 0; w < 7; w++) begin
                    a_send(rnd ? 8'($urandom) : 8'hA5, (w == gap_word) ? gap_len : 0);
                end
            end
            begin
                if (mid_start) begin
                    n = 0;
                    while (a_bit_idx != 6'd10 && n < 1000) begin
                        @(negedge clk);
                        n++;
                    end
                    check("a_mid_idx", 64'(a_bit_idx), 64'(10));
                    a_start = 1'b1;
                    @(negedge clk);
                    a_start = 1'b0;
                    check("a_mid_busy", 64'(a_busy), 64'(1));
                end
            end
        join
        n = 0;
        while (!a_done && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("a_done", 64'(a_done), 64'(1));
        check("a_latency", 64'(cyc - t0), 64'(exp_lat));
        check("a_end_busy", 64'(a_busy), 64'(0));
        check("a_end_bl", 64'(a_bl), 64'(0));
        check("a_end_wl", 64'(a_wl), 64'(0));
        check("a_end_ready", 64'(a_cfg_ready), 64'(0));
        check("a_end_idx", 64'(a_bit_idx), 64'(A_BITS));
        check("a_sb_drained", 64'(a_q.size()), 64'(0));
    endtask

    initial begin
        int n;
        int t0;
        rst = 1'b1;
        a_start = 1'b0; a_cfg_valid = 1'b0; a_cfg_data = '0;
        b_start = 1'b0; b_cfg_valid = 1'b0; b_cfg_data = '0;
        repeat (3) @(negedge clk);
        check("rst_a_bl", 64'(a_bl), 64'(0));
        check("rst_a_wl", 64'(a_wl), 64'(0));
        check("rst_a_ready", 64'(a_cfg_ready), 64'(0));
        check("rst_a_busy", 64'(a_busy), 64'(0));
        check("rst_a_done", 64'(a_done), 64'(0));
        check("rst_a_err", 64'(a_err), 64'(0));
        check("rst_a_idx", 64'(a_bit_idx), 64'(0));
        check("rst_b_busy", 64'(b_busy), 64'(0));
        rst = 1'b0;
        @(negedge clk);

        a_run(-1, 0, 1'b0, 1'b0, 231);
        a_run(2, 5, 1'b0, 1'b1, 236);
        a_run(-1, 0, 1'b1, 1'b1, 231);

        // Reset while wl[20] is high.
        a_nbits = 0;
        a_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
        for (int w = 0; w < 3; w++) a_send(8'($urandom), 0);
        n = 0;
        while (!a_wl[20] && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("a_wl20_seen", 64'(a_wl[20]), 64'(1));
        rst = 1'b1;
        @(negedge clk);
        check("midrst_wl", 64'(a_wl), 64'(0));
        check("midrst_bl", 64'(a_bl), 64'(0));
        check("midrst_busy", 64'(a_busy), 64'(0));
        check("midrst_ready", 64'(a_cfg_ready), 64'(0));
        @(posedge clk);
        #1 rst = 1'b0;
        a_q.delete();
        @(negedge clk);

        // cfg_valid while idle flags overflow and is not accepted.
        a_cfg_valid = 1'b1;
        @(negedge clk);
        a_cfg_valid = 1'b0;
        check("ovf_err", 64'(a_err), 64'(1));
        check("ovf_ready", 64'(a_cfg_ready), 64'(0));
        @(negedge clk);
        check("ovf_sticky", 64'(a_err), 64'(1));
        check("ovf_idle_busy", 64'(a_busy), 64'(0));
        a_run(-1, 0, 1'b0, 1'b1, 231);

        // Small geometry: 10 bits from two words, 3 cycles per bit.
        b_nbits = 0;
        b_start = 1'b1;
        @(negedge clk);
        b_start = 1'b0;
        t0 = cyc;
        b_send(8'($urandom));
        b_send(8'hFD);
        n = 0;
        while (!b_done && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("b_done", 64'(b_done), 64'(1));
        check("b_latency", 64'(cyc - t0), 64'(2 + 3 * B_BITS));
        check("b_end_idx", 64'(b_bit_idx), 64'(B_BITS));
        check("b_end_ready", 64'(b_cfg_ready), 64'(0));
        check("b_end_err", 64'(b_err), 64'(0));
        check("b_sb_drained", 64'(b_q.size()), 64'(0));
        repeat (3) @(negedge clk);
        check("b_done_sticky", 64'(b_done), 64'(1));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time bound");
        $fatal(1);
    end

endmodule
